// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller: one buffered request per port,
// watchdog abort after TIMEOUT cycles in WAIT. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p0_read,
    input  logic          p0_write,
    output logic          p0_busy,
    output logic          p0_ready,
    output logic [DW-1:0] p0_rdata,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic          p1_read,
    input  logic          p1_write,
    output logic          p1_busy,
    output logic          p1_ready,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic          mem_busy,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant,
    output logic          timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_pend, r_op, r_ready;
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];
    logic [DW-1:0] r_rdata [2];
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_read, r_mem_write, r_grant, r_timeout;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_rd, w_wr, w_fin;
    logic [AW-1:0] w_addr [2];
    logic [DW-1:0] w_wdata [2];
    logic          w_sel, w_issue, w_done, w_abort;

    assign w_rd    = {p1_read, p0_read};
    assign w_wr    = {p1_write, p0_write};
    assign w_addr  = '{p0_addr, p1_addr};
    assign w_wdata = '{p0_wdata, p1_wdata};
    assign w_fin   = {2{w_done | w_abort}} & {r_grant, ~r_grant};

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;

    // On a tie the port that did not win last time goes next.
    always_comb w_sel = (r_pend == 2'b11) ? ~r_last : r_pend[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_last <= 1'b1;
        else if (w_issue) r_last <= w_sel;
    end
`else
    always_comb w_sel = r_pend[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done || w_abort) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: w_issue = (|r_pend) && !mem_busy;
            S_WAIT: begin
                w_done  = mem_ready;
                w_abort = WD_EN && !mem_ready && (r_cnt == LIM);
            end
            default: ;
        endcase
    end

    // Pending slots: a strobe is taken only into an empty slot; read wins over write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_op   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_fin[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (!r_pend[i] && (w_rd[i] || w_wr[i])) begin
                    r_pend[i]  <= 1'b1;
                    r_op[i]    <= !w_rd[i];
                    r_addr[i]  <= w_addr[i];
                    r_wdata[i] <= w_wdata[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_grant     <= 1'b0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
            r_ready     <= '0;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ready     <= '0;
            if (w_issue) begin
                r_mem_addr  <= r_addr[w_sel];
                r_mem_wdata <= r_wdata[w_sel];
                r_mem_read  <= !r_op[w_sel];
                r_mem_write <= r_op[w_sel];
                r_grant     <= w_sel;
                r_cnt       <= '0;
            end
            if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
            if (w_done || w_abort) begin
                r_ready[r_grant] <= 1'b1;
                if (!r_op[r_grant]) r_rdata[r_grant] <= w_done ? mem_rdata : '1;
            end
            if (w_abort) r_timeout <= 1'b1;
        end
    end

    assign p0_busy     = r_pend[0];
    assign p1_busy     = r_pend[1];
    assign p0_ready    = r_ready[0];
    assign p1_ready    = r_ready[1];
    assign p0_rdata    = r_rdata[0];
    assign p1_rdata    = r_rdata[1];
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign grant       = r_grant;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected issues and completions are queued at drive time
// and compared when the DUT strobes memory or pulses a ready.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic        p0_busy, p0_ready, p1_busy, p1_ready;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_busy, mem_ready;
    logic        grant, timeout_err;

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read(p0_read), .p0_write(p0_write),
        .p0_busy(p0_busy), .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read(p1_read), .p1_write(p1_write),
        .p1_busy(p1_busy), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_busy(mem_busy), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit port; bit wr; logic [15:0] addr; logic [15:0] wdata; } iss_t;
    typedef struct { bit wr; logic [15:0] rdata; } rsp_t;

    iss_t iss_q[$];
    rsp_t rq0[$], rq1[$];
    int   n_chk = 0, n_pass = 0, n_iss = 0, cyc = 0, iss_cyc = 0, rdy_cyc0 = 0;
    int   model_lat = 3;
    logic [15:0] last0 = '0, last1 = '0;

    function automatic logic [15:0] f(input logic [15:0] a);
        return a ^ 16'hBEAF;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SDRAM stand-in: answers each strobe after model_lat cycles (0 = never answers).
    initial begin
        logic [15:0] a;
        logic        w;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if ((mem_read || mem_write) && model_lat > 0) begin
                a = mem_addr;
                w = mem_write;
                repeat (model_lat) @(negedge clk);
                mem_ready = 1'b1;
                mem_rdata = w ? 16'hDEAD : f(a);
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT issues or completes.
    initial forever begin
        iss_t e;
        rsp_t r;
        logic [15:0] x;
        @(negedge clk);
        if (!rst) begin
            if (mem_read || mem_write) begin
                n_iss++;
                iss_cyc = cyc;
                if (iss_q.size() == 0) check("iss_unexpected", 1, 0);
                else begin
                    e = iss_q.pop_front();
                    check("iss_grant", grant, e.port);
                    check("iss_write", mem_write, e.wr);
                    check("iss_read", mem_read, !e.wr);
                    check("iss_addr", mem_addr, e.addr);
                    if (e.wr) check("iss_wdata", mem_wdata, e.wdata);
                end
            end
            if (p0_ready) begin
                rdy_cyc0 = cyc;
                if (rq0.size() == 0) check("p0_ready_unexpected", 1, 0);
                else begin
                    r = rq0.pop_front();
                    x = r.wr ? last0 : r.rdata;
                    check("p0_rdata", p0_rdata, x);
                    last0 = x;
                end
            end
            if (p1_ready) begin
                if (rq1.size() == 0) check("p1_ready_unexpected", 1, 0);
                else begin
                    r = rq1.pop_front();
                    x = r.wr ? last1 : r.rdata;
                    check("p1_rdata", p1_rdata, x);
                    last1 = x;
                end
            end
        end
    end

    task automatic push(input bit port, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] rd_exp);
        iss_q.push_back('{port, wr, a, d});
        if (port) rq1.push_back('{wr, rd_exp});
        else      rq0.push_back('{wr, rd_exp});
    endtask

    task automatic req(input bit port, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit exp_issue);
        @(negedge clk);
        if (exp_issue) push(port, wr && !rd, a, d, f(a));
        if (port) begin p1_read = rd; p1_write = wr; p1_addr = a; p1_wdata = d; end
        else      begin p0_read = rd; p0_write = wr; p0_addr = a; p0_wdata = d; end
        @(negedge clk);
        p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((iss_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || p0_busy || p1_busy)
               && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_complete"}, k < 300, 1);
        @(negedge clk);
    endtask

    task automatic tie(input string tag, input bit p0_first);
        @(negedge clk);
        if (p0_first) begin
            push(0, 1, 16'h0010, 16'h1111, 16'h0);
            push(1, 0, 16'h0020, 16'h0, f(16'h0020));
        end else begin
            push(1, 0, 16'h0020, 16'h0, f(16'h0020));
            push(0, 1, 16'h0010, 16'h1111, 16'h0);
        end
        p0_write = 1; p0_addr = 16'h0010; p0_wdata = 16'h1111;
        p1_read  = 1; p1_addr = 16'h0020;
        @(negedge clk);
        p0_write = 0; p1_read = 0;
        wait_idle(tag);
    endtask

    initial begin
        int n0, k;
        bit first_p0;
        rst = 1; mem_busy = 0;
        p0_read = 0; p0_write = 0; p0_addr = 0; p0_wdata = 0;
        p1_read = 0; p1_write = 0; p1_addr = 0; p1_wdata = 0;
        #1;
        check("rst_busy", {p0_busy, p1_busy, p0_ready, p1_ready}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("rst_mem", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
        check("rst_grant_err", {grant, timeout_err}, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Simultaneous p0 write / p1 read, twice.
`ifdef ARB_ROUND_ROBIN_EN
        first_p0 = 1;
`else
        first_p0 = 0;
`endif
        tie("tie1", first_p0);
        tie("tie2", first_p0);

        // Single p0 read with a 3-cycle memory.
        n0 = n_iss;
        req(0, 1, 0, 16'h0040, 16'h0, 1);
        check("t1_busy_after_accept", p0_busy, 1);
        k = 0;
        while (!p0_ready && k < 50) begin @(negedge clk); k++; end
        check("t1_ready_seen", p0_ready, 1);
        check("t1_busy_clear", p0_busy, 0);
        check("t1_grant", grant, 0);
        check("t1_rdata", p0_rdata, 16'hBEEF);
        @(negedge clk);
        check("t1_ready_one_cycle", p0_ready, 0);
        check("t1_one_issue", n_iss - n0, 1);
        // Re-strobe the cycle right after the ready pulse.
        req(0, 1, 0, 16'h0041, 16'h0, 1);
        wait_idle("t1_back_to_back");

        // Memory busy holds off the issue.
        mem_busy = 1;
        n0 = n_iss;
        req(1, 1, 0, 16'h0077, 16'h0, 1);
        repeat (10) @(negedge clk);
        check("t3_no_issue_while_busy", n_iss - n0, 0);
        mem_busy = 0;
        @(negedge clk);
        check("t3_issue_after_release", mem_read, 1);
        wait_idle("t3");

        // Second strobe while busy is ignored; read+write together reads.
        n0 = n_iss;
        req(0, 1, 1, 16'h0400, 16'h5555, 1);
        req(0, 0, 1, 16'h0500, 16'h6666, 0);
        wait_idle("t6");
        check("t6_one_issue", n_iss - n0, 1);

        // Watchdog: memory answers too late.
        model_lat = 12;
        req(0, 1, 0, 16'h0100, 16'h0, 0);
        iss_q.push_back('{1'b0, 1'b0, 16'h0100, 16'h0});
        rq0.push_back('{1'b0, 16'hFFFF});
        wait_idle("t4");
        check("t4_abort_latency", rdy_cyc0 - iss_cyc, 8);
        check("t4_timeout_err", timeout_err, 1);
        repeat (15) @(negedge clk);
        check("t4_timeout_sticky", timeout_err, 1);
        check("t4_rdata_held", p0_rdata, 16'hFFFF);

        // Asynchronous reset during WAIT.
        model_lat = 6;
        n0 = n_iss;
        req(1, 1, 0, 16'h0200, 16'h0, 1);
        k = 0;
        while (n_iss == n0 && k < 20) begin @(negedge clk); k++; end
        check("t5_issued", n_iss - n0, 1);
        #2 rst = 1;
        #1;
        check("t5_rst_busy", {p0_busy, p1_busy, p0_ready, p1_ready}, 0);
        check("t5_rst_mem", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
        check("t5_rst_grant_err", {grant, timeout_err}, 0);
        check("t5_rst_rdata", {p0_rdata, p1_rdata}, 0);
        iss_q.delete(); rq0.delete(); rq1.delete();
        last0 = '0; last1 = '0;
        @(negedge clk);
        mem_busy = 1;
        rst = 0;
        repeat (10) @(negedge clk);
        n0 = n_iss;
        req(1, 1, 0, 16'h0300, 16'h0, 1);
        repeat (4) @(negedge clk);
        check("t5_hold_while_mem_busy", n_iss - n0, 0);
        mem_busy = 0;
        wait_idle("t5");
        check("t5_one_issue", n_iss - n0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
